// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM state
// encodings, opcode/funct constants, ALU operation codes, datapath select
// codes and trap causes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_e;

    // Instruction classes that steer the sequencing in EX/MEM/WB.
    typedef enum logic [2:0] {
        CL_RTYPE  = 3'd0,
        CL_IMM    = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_J      = 3'd5,
        CL_JAL    = 3'd6,
        CL_JR     = 3'd7
    } iclass_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // ALU operation codes; zero is reserved for "no operation / unknown"
    localparam logic [4:0] ALUOP_NONE = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_ADDU = 5'd2;
    localparam logic [4:0] ALUOP_SUB  = 5'd3;
    localparam logic [4:0] ALUOP_SUBU = 5'd4;
    localparam logic [4:0] ALUOP_AND  = 5'd5;
    localparam logic [4:0] ALUOP_OR   = 5'd6;
    localparam logic [4:0] ALUOP_XOR  = 5'd7;
    localparam logic [4:0] ALUOP_NOR  = 5'd8;
    localparam logic [4:0] ALUOP_SLT  = 5'd9;
    localparam logic [4:0] ALUOP_SLTU = 5'd10;
    localparam logic [4:0] ALUOP_SLL  = 5'd11;
    localparam logic [4:0] ALUOP_SRL  = 5'd12;
    localparam logic [4:0] ALUOP_SRA  = 5'd13;
    localparam logic [4:0] ALUOP_LUI  = 5'd14;

    // PC source select
    localparam logic [1:0] PCSEL_PC4    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_RS     = 2'b11;

    // Register destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Writeback source select
    localparam logic [1:0] WBSRC_ALU = 2'b00;
    localparam logic [1:0] WBSRC_MEM = 2'b01;
    localparam logic [1:0] WBSRC_PC  = 2'b10;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    // Map an R-type funct field to its ALU operation; ALUOP_NONE if unknown.
    function automatic logic [4:0] rtype_aluop(input logic [5:0] fn);
        logic [4:0] op;
        case (fn)
            FN_ADD:  op = ALUOP_ADD;
            FN_ADDU: op = ALUOP_ADDU;
            FN_SUB:  op = ALUOP_SUB;
            FN_SUBU: op = ALUOP_SUBU;
            FN_AND:  op = ALUOP_AND;
            FN_OR:   op = ALUOP_OR;
            FN_XOR:  op = ALUOP_XOR;
            FN_NOR:  op = ALUOP_NOR;
            FN_SLT:  op = ALUOP_SLT;
            FN_SLTU: op = ALUOP_SLTU;
            FN_SLL:  op = ALUOP_SLL;
            FN_SRL:  op = ALUOP_SRL;
            FN_SRA:  op = ALUOP_SRA;
            default: op = ALUOP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Shared memory port between the control unit (master) and memory (slave).
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder: opcode/func to per-instruction fields.
// Jump instructions (j, jal, jr) are only legal when MC_CTRL_JUMP_EN is
// defined; otherwise they are flagged illegal.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 5
) (
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         func_i,
    output logic [ALUOP_W-1:0] alu_ctrl_o,
    output logic               alu_src_o,
    output logic               ext_op_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         data_to_reg_o,
    output iclass_e            iclass_o,
    output logic               illegal_o
);

    logic [4:0] aluop_s;

    // Decode table: defaults first, then per-opcode overrides
    always_comb begin
        aluop_s       = ALUOP_NONE;
        alu_src_o     = 1'b0;
        ext_op_o      = 1'b0;
        reg_dst_o     = REGDST_RT;
        data_to_reg_o = WBSRC_ALU;
        iclass_o      = CL_RTYPE;
        illegal_o     = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                reg_dst_o = REGDST_RD;
                if (func_i == FN_JR) begin
`ifdef MC_CTRL_JUMP_EN
                    iclass_o  = CL_JR;
                    reg_dst_o = REGDST_RT;
`else
                    illegal_o = 1'b1;
`endif
                end else begin
                    aluop_s   = rtype_aluop(func_i);
                    illegal_o = (aluop_s == ALUOP_NONE);
                end
            end
            OP_ADDI: begin
                iclass_o = CL_IMM;  aluop_s = ALUOP_ADD;
                alu_src_o = 1'b1;   ext_op_o = 1'b1;
            end
            OP_SLTI: begin
                iclass_o = CL_IMM;  aluop_s = ALUOP_SLT;
                alu_src_o = 1'b1;   ext_op_o = 1'b1;
            end
            OP_ORI: begin
                iclass_o = CL_IMM;  aluop_s = ALUOP_OR;
                alu_src_o = 1'b1;   ext_op_o = 1'b0;
            end
            OP_LUI: begin
                iclass_o = CL_IMM;  aluop_s = ALUOP_LUI;
                alu_src_o = 1'b1;   ext_op_o = 1'b0;
            end
            OP_LW: begin
                iclass_o = CL_LOAD; aluop_s = ALUOP_ADD;
                alu_src_o = 1'b1;   ext_op_o = 1'b1;
                data_to_reg_o = WBSRC_MEM;
            end
            OP_SW: begin
                iclass_o = CL_STORE; aluop_s = ALUOP_ADD;
                alu_src_o = 1'b1;    ext_op_o = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                iclass_o = CL_BRANCH; aluop_s = ALUOP_SUB;
                alu_src_o = 1'b0;     ext_op_o = 1'b1;
            end
            OP_J: begin
`ifdef MC_CTRL_JUMP_EN
                iclass_o = CL_J;
`else
                illegal_o = 1'b1;
`endif
            end
            OP_JAL: begin
`ifdef MC_CTRL_JUMP_EN
                iclass_o      = CL_JAL;
                reg_dst_o     = REGDST_RA;
                data_to_reg_o = WBSRC_PC;
`else
                illegal_o = 1'b1;
`endif
            end
            default: illegal_o = 1'b1;
        endcase
        alu_ctrl_o = ALUOP_W'(aluop_s);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit. Sequences IF/ID/EX/MEM/WB over one shared
// memory port, with memory wait states, a memory timeout trap and an
// illegal-instruction trap. Only the state, wait counter and trap flags are
// registered; all other outputs decode combinationally from the state and
// the instruction fields and are held low while rst is asserted.
// Optional: define MC_CTRL_JUMP_EN to enable j / jal / jr.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    mc_ctrl_if.master          mem,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PC_sel,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         DatatoReg,
    output logic               ALUSrc,
    output logic               ExtOp,
    output logic [ALUOP_W-1:0] ALUCtrl,
    output logic [2:0]         state_o,
    output logic               instr_done,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam bit               TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_q, trap_d;
    logic [1:0]         cause_q, cause_d;

    // Decoder fields
    logic [ALUOP_W-1:0] dec_alu_s;
    logic               dec_src_s, dec_ext_s, dec_illegal_s;
    logic [1:0]         dec_rd_s, dec_dtr_s;
    iclass_e            dec_class_s;

    // Un-gated FSM outputs
    logic               req_s, we_s, iord_s, irw_s, pcw_s, rw_s, ext_s, src_s, done_s;
    logic [1:0]         pcs_s, rd_s, dtr_s, cause_s;
    logic [ALUOP_W-1:0] alu_s;
    logic               timeout_s, taken_s;

    mc_ctrl_decode #(.ALUOP_W(ALUOP_W)) u_decode (
        .opcode_i      (opcode),
        .func_i        (func),
        .alu_ctrl_o    (dec_alu_s),
        .alu_src_o     (dec_src_s),
        .ext_op_o      (dec_ext_s),
        .reg_dst_o     (dec_rd_s),
        .data_to_reg_o (dec_dtr_s),
        .iclass_o      (dec_class_s),
        .illegal_o     (dec_illegal_s)
    );

    assign timeout_s = TIMEOUT_EN && (cnt_q == TIMEOUT_CNT);
    assign taken_s   = (opcode == OP_BEQ) ? zero : ~zero;

    // Next-state and per-state datapath controls
    always_comb begin
        state_d = state_q;
        req_s = 1'b0; we_s = 1'b0; iord_s = 1'b0; irw_s = 1'b0;
        pcw_s = 1'b0; rw_s = 1'b0; src_s = 1'b0; ext_s = 1'b0;
        done_s = 1'b0;
        pcs_s = PCSEL_PC4; rd_s = REGDST_RT; dtr_s = WBSRC_ALU;
        alu_s = '0;
        cause_s = TRAP_NONE;
        case (state_q)
            ST_IF: begin
                req_s = 1'b1;
                if (mem.mem_ready) begin
                    irw_s = 1'b1; pcw_s = 1'b1; pcs_s = PCSEL_PC4;
                    state_d = ST_ID;
                end else if (timeout_s) begin
                    state_d = ST_TRAP; cause_s = TRAP_TIMEOUT;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_ID: begin
                if (dec_illegal_s) begin
                    state_d = ST_TRAP; cause_s = TRAP_ILLEGAL;
                end else if (dec_class_s == CL_J) begin
                    pcw_s = 1'b1; pcs_s = PCSEL_JUMP; done_s = 1'b1;
                    state_d = ST_IF;
                end else if (dec_class_s == CL_JAL) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                alu_s = dec_alu_s; src_s = dec_src_s; ext_s = dec_ext_s;
                case (dec_class_s)
                    CL_BRANCH: begin
                        pcw_s = taken_s; pcs_s = PCSEL_BRANCH; done_s = 1'b1;
                        state_d = ST_IF;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_JR: begin
                        pcw_s = 1'b1; pcs_s = PCSEL_RS; done_s = 1'b1;
                        state_d = ST_IF;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                req_s = 1'b1; iord_s = 1'b1;
                we_s  = (dec_class_s == CL_STORE);
                if (mem.mem_ready) begin
                    if (dec_class_s == CL_STORE) begin
                        done_s = 1'b1; state_d = ST_IF;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_s) begin
                    state_d = ST_TRAP; cause_s = TRAP_TIMEOUT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                rw_s = 1'b1; rd_s = dec_rd_s; dtr_s = dec_dtr_s; done_s = 1'b1;
                if (dec_class_s == CL_JAL) begin
                    pcw_s = 1'b1; pcs_s = PCSEL_JUMP;
                end else begin
                    pcw_s = 1'b0;
                end
                state_d = ST_IF;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IF;
        endcase
    end

    // Wait counter: clear on entry to IF/MEM, count stalled cycles, saturate
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM))) begin
            cnt_d = '0;
        end else if (req_s && !mem.mem_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Trap flags latch on entry to TRAP and then hold until reset
    always_comb begin
        trap_d  = trap_q;
        cause_d = cause_q;
        if ((state_d == ST_TRAP) && (state_q != ST_TRAP)) begin
            trap_d  = 1'b1;
            cause_d = cause_s;
        end else begin
            trap_d  = trap_q;
        end
    end

    // State, counter and trap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IF;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Output drive; everything held low while rst is asserted
    always_comb begin
        if (rst) begin
            mem.mem_req = 1'b0; mem.mem_we = 1'b0;
            IorD = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; PC_sel = 2'b00;
            RegWrite = 1'b0; RegDst = 2'b00; DatatoReg = 2'b00;
            ALUSrc = 1'b0; ExtOp = 1'b0; ALUCtrl = '0;
            state_o = 3'd0; instr_done = 1'b0; trap = 1'b0; trap_cause = 2'b00;
        end else begin
            mem.mem_req = req_s; mem.mem_we = we_s;
            IorD = iord_s; IRWrite = irw_s; PCWrite = pcw_s; PC_sel = pcs_s;
            RegWrite = rw_s; RegDst = rd_s; DatatoReg = dtr_s;
            ALUSrc = src_s; ExtOp = ext_s; ALUCtrl = alu_s;
            state_o = state_q; instr_done = done_s;
            trap = trap_q; trap_cause = cause_q;
        end
    end

endmodule
